sha256_round_ctrl: RTL and testbench



---
 rtl/sha256_round_ctrl.sv | 75 +++++++
 tb/tb_sha256_round_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: sequences one SHA-256 compression (load, ROUNDS rounds, chaining add).
// Define SHA256_CTRL_STALL_EN to let w_valid stall the rounds; otherwise every RUN cycle is a round.
module sha256_round_ctrl #(
    parameter int ROUNDS = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      first_blk,
    input  logic                      w_valid,
    output logic                      w_ready,
    output logic [$clog2(ROUNDS)-1:0] round_idx,
    output logic                      dp_load,
    output logic                      dp_en,
    input  logic [255:0]              st_in,
    output logic [255:0]              chain_out,
    output logic                      busy,
    output logic                      done
);
    localparam int RW = $clog2(ROUNDS);
    localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);
    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    typedef enum logic [1:0] {IDLE, LOAD, RUN, ADD} state_t;
    state_t state;

`ifdef SHA256_CTRL_STALL_EN
    assign dp_en = (state == RUN) && w_valid;
`else
    logic unused_w_valid;
    assign unused_w_valid = w_valid;
    assign dp_en = (state == RUN);
`endif
    assign w_ready = dp_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            round_idx <= '0;
            chain_out <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            dp_load   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state   <= LOAD;
                    busy    <= 1'b1;
                    dp_load <= 1'b1;
                    if (first_blk) chain_out <= IV;
                end
                LOAD: begin
                    state     <= RUN;
                    dp_load   <= 1'b0;
                    round_idx <= '0;
                end
                RUN: if (dp_en) begin
                    round_idx <= (round_idx == LAST) ? '0 : round_idx + RW'(1);
                    if (round_idx == LAST) state <= ADD;
                end
                ADD: begin
                    // word-wise mod 2^32 add, no carry between words
                    for (int i = 0; i < 8; i++)
                        chain_out[32*i +: 32] <= chain_out[32*i +: 32] + st_in[32*i +: 32];
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb_sha256_round_ctrl: random and directed checks of sha256_round_ctrl against a
// behavioural SHA-256 model; a stub datapath applies real rounds to supply st_in.
module tb_sha256_round_ctrl;
    localparam int ROUNDS = 64;
`ifdef SHA256_CTRL_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif
    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] ABC_DIGEST = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                           32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, first_blk = 1'b0, w_valid = 1'b0;
    logic w_ready, dp_load, dp_en, busy, done;
    logic [5:0] round_idx;
    logic [255:0] st_in, chain_out, st;
    logic [31:0] w_sched [64];
    bit force_ff = 1'b0;
    int compared = 0, mismatched = 0;
    logic [255:0] prev = '0;

    sha256_round_ctrl #(.ROUNDS(ROUNDS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .first_blk(first_blk), .w_valid(w_valid),
        .w_ready(w_ready), .round_idx(round_idx), .dp_load(dp_load), .dp_en(dp_en),
        .st_in(st_in), .chain_out(chain_out), .busy(busy), .done(done));

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] rnd(input logic [255:0] s, input logic [31:0] k, input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    function automatic void expand(input logic [511:0] blk, output logic [31:0] w [64]);
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [255:0] s, r;
        expand(blk, w);
        s = h;
        for (int t = 0; t < 64; t++) s = rnd(s, K[t], w[t]);
        for (int i = 0; i < 8; i++) r[32*i +: 32] = h[32*i +: 32] + s[32*i +: 32];
        return r;
    endfunction

    // stub round datapath fed by the controller's strobes
    always @(posedge clk)
        if (dp_load) st <= chain_out;
        else if (dp_en) st <= rnd(st, K[round_idx], w_sched[round_idx]);
    assign st_in = force_ff ? '1 : st;

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // drives one block from the current (IDLE) cycle = cycle 0 until done; checks strobes each cycle
    task automatic drive_block(input bit fb, input logic [511:0] blk, input bit ff, input int stall_at,
                               input int stall_len, input bit rnd_valid, input int pulse_at,
                               input bit hold, output int done_at, output int exp_at);
        int cyc = 0, vcnt = 0, stall_left = stall_len;
        bit in_run, stalling = 1'b0, exp_en, exp_busy;
        expand(blk, w_sched);
        force_ff = ff;
        start = 1'b1; first_blk = fb; w_valid = 1'b0;
        done_at = -1; exp_at = -1;
        while (cyc < 300) begin
            @(posedge clk); #1; cyc++;
            in_run = cyc >= 2 && vcnt < ROUNDS;
            start = hold || (in_run && vcnt == pulse_at);
            w_valid = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (in_run && vcnt == stall_at) stalling = 1'b1;
            if (stalling && stall_left > 0) begin w_valid = 1'b0; stall_left--; end
            exp_en = in_run && (STALL ? w_valid : 1'b1);
            exp_busy = cyc >= 1 && (exp_at < 0 || cyc < exp_at);
            #1;
            compared++;
            if (dp_en !== exp_en) begin mismatched++; $display("FAIL dp_en c%0d: got %b want %b", cyc, dp_en, exp_en); end
            compared++;
            if (w_ready !== exp_en) begin mismatched++; $display("FAIL w_ready c%0d: got %b want %b", cyc, w_ready, exp_en); end
            compared++;
            if (dp_load !== (cyc == 1)) begin mismatched++; $display("FAIL dp_load c%0d: got %b want %b", cyc, dp_load, cyc == 1); end
            compared++;
            if (busy !== exp_busy) begin mismatched++; $display("FAIL busy c%0d: got %b want %b", cyc, busy, exp_busy); end
            compared++;
            if (done !== (cyc == exp_at)) begin mismatched++; $display("FAIL done c%0d: got %b want %b", cyc, done, cyc == exp_at); end
            compared++;
            if (int'(round_idx) !== (in_run ? vcnt : 0)) begin
                mismatched++; $display("FAIL round_idx c%0d: got %0d want %0d", cyc, round_idx, in_run ? vcnt : 0);
            end
            if (done === 1'b1) done_at = cyc;
            if (exp_en) begin vcnt++; if (vcnt == ROUNDS) exp_at = cyc + 2; end
            if (done_at >= 0 || (exp_at >= 0 && cyc >= exp_at)) break;
        end
        compared++;
        if (cyc >= 300) begin mismatched++; $display("FAIL timeout: got no done after %0d cycles, want one", cyc); end
        if (!hold) start = 1'b0;
        w_valid = 1'b0;
        force_ff = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; w_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        compared++;
        if ({busy, done, dp_load, dp_en, w_ready} !== 5'b0) begin
            mismatched++; $display("FAIL reset_strobes: got %b want 00000", {busy, done, dp_load, dp_en, w_ready});
        end
        compared++;
        if (round_idx !== 6'd0) begin mismatched++; $display("FAIL reset_idx: got %0d want 0", round_idx); end
        compared++;
        if (chain_out !== '0) begin mismatched++; $display("FAIL reset_chain: got %h want 0", chain_out); end
        start = 1'b0; w_valid = 1'b0; rst_n = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic test_abc(input string tag);
        int d, e;
        drive_block(1'b1, ABC_BLK, 1'b0, -1, 0, 1'b0, -1, 1'b0, d, e);
        prev = compress(IV, ABC_BLK);
        compared++;
        if (d !== 67) begin mismatched++; $display("FAIL %s_done_cycle: got %0d want 67", tag, d); end
        compared++;
        if (chain_out !== ABC_DIGEST) begin mismatched++; $display("FAIL %s_digest: got %h want %h", tag, chain_out, ABC_DIGEST); end
        compared++;
        if (prev !== ABC_DIGEST) begin mismatched++; $display("FAIL %s_model: got %h want %h", tag, prev, ABC_DIGEST); end
        @(posedge clk); #2;
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("FAIL %s_done_width: got %b want 0", tag, done); end
    endtask

    task automatic test_wrap_no_carry();
        int d, e;
        logic [255:0] exp_c;
        drive_block(1'b1, ABC_BLK, 1'b1, -1, 0, 1'b0, -1, 1'b0, d, e);
        for (int i = 0; i < 8; i++) exp_c[32*i +: 32] = IV[32*i +: 32] - 32'd1;
        prev = exp_c;
        compared++;
        if (chain_out[255:224] !== 32'h6a09e666) begin mismatched++; $display("FAIL wrap_h0: got %h want 6a09e666", chain_out[255:224]); end
        compared++;
        if (chain_out[31:0] !== 32'h5be0cd18) begin mismatched++; $display("FAIL wrap_h7: got %h want 5be0cd18", chain_out[31:0]); end
        compared++;
        if (chain_out !== exp_c) begin mismatched++; $display("FAIL wrap_all: got %h want %h", chain_out, exp_c); end
    endtask

    task automatic test_stall();
        int d, e;
        drive_block(1'b1, ABC_BLK, 1'b0, 10, 5, 1'b0, -1, 1'b0, d, e);
        prev = ABC_DIGEST;
        compared++;
        if (d !== (STALL ? 72 : 67)) begin mismatched++; $display("FAIL stall_done_cycle: got %0d want %0d", d, STALL ? 72 : 67); end
        compared++;
        if (chain_out !== ABC_DIGEST) begin mismatched++; $display("FAIL stall_digest: got %h want %h", chain_out, ABC_DIGEST); end
    endtask

    task automatic test_start_ignored();
        int d, e;
        logic [511:0] b = rand_blk();
        drive_block(1'b0, b, 1'b0, -1, 0, 1'b0, 20, 1'b0, d, e);
        prev = compress(prev, b);
        compared++;
        if (d !== 67) begin mismatched++; $display("FAIL ignored_done_cycle: got %0d want 67", d); end
        compared++;
        if (chain_out !== prev) begin mismatched++; $display("FAIL ignored_digest: got %h want %h", chain_out, prev); end
        @(posedge clk); #2;
        compared++;
        if ({busy, dp_load} !== 2'b00) begin mismatched++; $display("FAIL ignored_requeue: got %b want 00", {busy, dp_load}); end
    endtask

    task automatic test_back_to_back();
        int d, e;
        logic [511:0] b1 = rand_blk(), b2 = rand_blk();
        drive_block(1'b1, b1, 1'b0, -1, 0, 1'b0, -1, 1'b1, d, e);
        prev = compress(IV, b1);
        compared++;
        if (d !== 67) begin mismatched++; $display("FAIL b2b_first_done: got %0d want 67", d); end
        compared++;
        if (chain_out !== prev) begin mismatched++; $display("FAIL b2b_first_digest: got %h want %h", chain_out, prev); end
        drive_block(1'b0, b2, 1'b0, -1, 0, 1'b0, -1, 1'b0, d, e);
        prev = compress(prev, b2);
        compared++;
        if (d !== 67) begin mismatched++; $display("FAIL b2b_second_done: got %0d want 67", d); end
        compared++;
        if (chain_out !== prev) begin mismatched++; $display("FAIL b2b_chained_digest: got %h want %h", chain_out, prev); end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        expand(ABC_BLK, w_sched);
        start = 1'b1; first_blk = 1'b1; w_valid = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #1; start = 1'b0; #1;
            seen = busy === 1'b1 && round_idx === 6'd30;
        end
        compared++;
        if (!seen) begin mismatched++; $display("FAIL mid_reach30: got no round 30, want it"); end
        rst_n = 1'b0;
        @(posedge clk); #2;
        compared++;
        if ({busy, done, dp_load, dp_en, w_ready} !== 5'b0) begin
            mismatched++; $display("FAIL mid_strobes: got %b want 00000", {busy, done, dp_load, dp_en, w_ready});
        end
        compared++;
        if (round_idx !== 6'd0) begin mismatched++; $display("FAIL mid_idx: got %0d want 0", round_idx); end
        compared++;
        if (chain_out !== '0) begin mismatched++; $display("FAIL mid_chain: got %h want 0", chain_out); end
        rst_n = 1'b1; seen = 1'b0;
        repeat (80) begin @(posedge clk); #2; if (done === 1'b1 || busy === 1'b1) seen = 1'b1; end
        compared++;
        if (seen) begin mismatched++; $display("FAIL mid_no_done: got activity after reset, want none"); end
        w_valid = 1'b0;
        prev = '0;
    endtask

    task automatic test_random();
        int d, e;
        bit fb;
        logic [511:0] b;
        for (int n = 0; n < 4; n++) begin
            b = rand_blk();
            fb = (n == 0) || ($urandom_range(0, 1) == 1);
            drive_block(fb, b, 1'b0, -1, 0, 1'b1, -1, 1'b0, d, e);
            prev = compress(fb ? IV : prev, b);
            compared++;
            if (d !== e || d < 67) begin mismatched++; $display("FAIL rand%0d_done_cycle: got %0d want %0d", n, d, e); end
            compared++;
            if (chain_out !== prev) begin mismatched++; $display("FAIL rand%0d_digest: got %h want %h", n, chain_out, prev); end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #2;
        end
    endtask

    initial begin
        test_reset();
        test_abc("abc");
        test_wrap_no_carry();
        test_stall();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_abc("abc_again");
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
